// File: rtl/lif_array_pkg.sv
// Shared definitions for the LIF neuron blocks: sweep FSM states, the default
// firing threshold and a helper that sizes the refractory counters.
package lif_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } lif_state_e;

    localparam int THR_RST_DEFAULT = 230;

    // A refractory period of 0 still needs a 1-bit counter so the ports stay legal.
    function automatic int refrac_width(input int refrac);
        return (refrac > 0) ? $clog2(refrac + 1) : 1;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron update: leak, saturating integrate, threshold
// compare and refractory handling for one membrane potential.
module lif_update #(
    parameter int STATE_W    = 8,
    parameter int CUR_W      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int REF_W      = 2
) (
    input  logic [STATE_W-1:0] s,
    input  logic [REF_W-1:0]   r,
    input  logic [CUR_W-1:0]   cur,
    input  logic [STATE_W-1:0] thr,
    output logic [STATE_W-1:0] s_next,
    output logic [REF_W-1:0]   r_next,
    output logic               spike
);

    logic [STATE_W-1:0] s_leak;
    logic [STATE_W:0]   sum;
    logic [STATE_W-1:0] v;

    // The extra carry bit of sum flags overflow, which clamps to all-ones.
    always_comb begin
        s_leak = s - (s >> LEAK_SHIFT);
        sum    = {1'b0, s_leak} + {{(STATE_W + 1 - CUR_W){1'b0}}, cur};
        v      = sum[STATE_W] ? '1 : sum[STATE_W-1:0];
        s_next = v;
        r_next = '0;
        spike  = 1'b0;
        if (r != '0) begin
            s_next = '0;
            r_next = r - REF_W'(1);
        end else if (v >= thr) begin
            spike  = 1'b1;
            s_next = '0;
            r_next = REF_W'(REFRAC);
        end
    end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons. Each tick starts
// a sweep that pushes every neuron through one shared lif_update datapath.
module lif_array
    import lif_array_pkg::*;
#(
    parameter  int N_NEURONS  = 8,
    parameter  int STATE_W    = 8,
    parameter  int CUR_W      = 4,
    parameter  int LEAK_SHIFT = 3,
    parameter  int REFRAC     = 2,
    parameter  int THR_RST    = THR_RST_DEFAULT,
    localparam int IDX_W      = $clog2(N_NEURONS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [N_NEURONS*CUR_W-1:0] current,
    input  logic                       thr_we,
    input  logic [STATE_W-1:0]         thr_wdata,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [STATE_W-1:0]         rd_state,
    output logic                       busy,
    output logic [N_NEURONS-1:0]       spikes,
    output logic                       spike_valid,
    output logic                       tick_overrun
);

    localparam int              REF_W    = refrac_width(REFRAC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_e                 state;
    logic [IDX_W-1:0]           idx;
    logic [N_NEURONS*CUR_W-1:0] cur_q;
    logic [STATE_W-1:0]         thr_q;
    logic [STATE_W-1:0]         threshold;
    logic [STATE_W-1:0]         potential [N_NEURONS];
    logic [REF_W-1:0]           refrac_cnt [N_NEURONS];
    logic [N_NEURONS-1:0]       spike_acc;
    logic [N_NEURONS-1:0]       spike_acc_next;

    logic [STATE_W-1:0]         upd_s;
    logic [STATE_W-1:0]         upd_s_next;
    logic [REF_W-1:0]           upd_r;
    logic [REF_W-1:0]           upd_r_next;
    logic [CUR_W-1:0]           upd_cur;
    logic                       upd_spike;

    // Steer the neuron selected by idx into the shared update datapath.
    always_comb begin
        upd_s               = potential[idx];
        upd_r               = refrac_cnt[idx];
        upd_cur             = cur_q[idx*CUR_W +: CUR_W];
        spike_acc_next      = spike_acc;
        spike_acc_next[idx] = upd_spike;
    end

    lif_update #(
        .STATE_W    (STATE_W),
        .CUR_W      (CUR_W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .REF_W      (REF_W)
    ) u_update (
        .s      (upd_s),
        .r      (upd_r),
        .cur    (upd_cur),
        .thr    (thr_q),
        .s_next (upd_s_next),
        .r_next (upd_r_next),
        .spike  (upd_spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            threshold <= STATE_W'(THR_RST);
        end else if (thr_we) begin
            threshold <= thr_wdata;
        end
    end

    // Sweep control. A write coinciding with the accepting tick bypasses the
    // threshold register so that sweep already sees the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            cur_q        <= '0;
            thr_q        <= '0;
            spike_acc    <= '0;
            spikes       <= '0;
            spike_valid  <= 1'b0;
            busy         <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    spike_valid <= 1'b0;
                    if (tick) begin
                        cur_q     <= current;
                        thr_q     <= thr_we ? thr_wdata : threshold;
                        idx       <= '0;
                        spike_acc <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (tick) begin
                        tick_overrun <= 1'b1;
                    end
                    spike_acc <= spike_acc_next;
                    if (idx == LAST_IDX) begin
                        spikes      <= spike_acc_next;
                        spike_valid <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (tick) begin
                        tick_overrun <= 1'b1;
                    end
                    spike_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                potential[i]  <= '0;
                refrac_cnt[i] <= '0;
            end
        end else if (state == ST_SWEEP) begin
            potential[idx]  <= upd_s_next;
            refrac_cnt[idx] <= upd_r_next;
        end
    end

    // Out-of-range indices (only possible when N_NEURONS is not a power of two) read as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= '0;
        end else if (int'(rd_idx) < N_NEURONS) begin
            rd_state <= potential[rd_idx];
        end else begin
            rd_state <= '0;
        end
    end

endmodule
